// File: rtl/ascon_block_feeder.sv
// Block FIFO and handshake between the register layer and the Ascon-128a core,
// with ct/tag capture and status byte. Optional push-time padding: ASCON_FEEDER_PAD_EN.
module ascon_block_feeder #(
    parameter int pDEPTH = 2
) (
    input  logic         crypto_clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         reg_push_i,
    input  logic [127:0] reg_data_i,
    input  logic [4:0]   reg_vbytes_i,
    input  logic         reg_last_i,
    input  logic         reg_eot_i,
    input  logic         reg_sel_i,
    output logic         reg_full_o,
    output logic [127:0] core_data_o,
    output logic [4:0]   core_vbytes_o,
    output logic         core_last_o,
    output logic         core_eot_o,
    output logic         core_sel_o,
    output logic         core_valid_o,
    input  logic         core_ready_i,
    input  logic [127:0] core_ct_i,
    input  logic         core_ct_valid_i,
    input  logic [127:0] core_tag_i,
    input  logic         core_tag_valid_i,
    input  logic         core_done_i,
    output logic [127:0] ct_o,
    output logic [127:0] tag_o,
    output logic [7:0]   status_o
);

    localparam int PTR_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
    localparam int CNT_W = $clog2(pDEPTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               read_data_core;
    logic               ct_valid;
    logic               ready_tag;
    logic               done;
    logic               overflow;

    logic [127:0]       mem_data [pDEPTH];
    logic [4:0]         mem_vbytes [pDEPTH];
    logic [2:0]         mem_flags [pDEPTH];

    logic               full;
    logic               has_data;
    logic               push_ok;
    logic               pop;
    logic [4:0]         vbytes_sat;
    logic [127:0]       data_in;

    function automatic logic [127:0] pad_block(input logic [127:0] d, input logic [4:0] vb);
        logic [127:0] r;
        r = d;
        if (vb < 5'd16) begin
            for (int i = 0; i < 16; i++) begin
                if (i == int'(vb))
                    r[127-8*i -: 8] = 8'h80;
                else if (i > int'(vb))
                    r[127-8*i -: 8] = 8'h00;
            end
        end
        return r;
    endfunction

    assign full       = (count == CNT_W'(pDEPTH));
    assign has_data   = (count != '0);
    assign push_ok    = reg_push_i && !full;
    assign pop        = core_valid_o && core_ready_i;
    assign vbytes_sat = (reg_vbytes_i > 5'd16) ? 5'd16 : reg_vbytes_i;

`ifdef ASCON_FEEDER_PAD_EN
    assign data_in = pad_block(reg_data_i, vbytes_sat);
`else
    assign data_in = reg_data_i;
`endif

    // Empty FIFO presents zeros, so stale entries never leak to the core.
    assign core_valid_o  = (state == RUN) && has_data;
    assign core_data_o   = has_data ? mem_data[rd_ptr]   : '0;
    assign core_vbytes_o = has_data ? mem_vbytes[rd_ptr] : '0;
    assign core_last_o   = has_data && mem_flags[rd_ptr][2];
    assign core_eot_o    = has_data && mem_flags[rd_ptr][1];
    assign core_sel_o    = has_data && mem_flags[rd_ptr][0];
    assign reg_full_o    = full;
    assign status_o      = {2'b00, overflow, done, ready_tag, ct_valid, read_data_core,
                            (state == RUN)};

    // NOTE: storage is not reset; the count gate above makes its contents unobservable.
    always_ff @(posedge crypto_clk) begin
        if (push_ok) begin
            mem_data[wr_ptr]   <= data_in;
            mem_vbytes[wr_ptr] <= vbytes_sat;
            mem_flags[wr_ptr]  <= {reg_last_i, reg_eot_i, reg_sel_i};
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge crypto_clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            read_data_core <= 1'b0;
            ct_valid       <= 1'b0;
            ready_tag      <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            ct_o           <= '0;
            tag_o          <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    state     <= RUN;
                    done      <= 1'b0;
                    ct_valid  <= 1'b0;
                    ready_tag <= 1'b0;
                    overflow  <= 1'b0;
                end
                RUN: if (core_done_i) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Later assignments win: a pop beats a same-cycle push, strobes beat start.
            if (push_ok)             read_data_core <= 1'b0;
            if (pop)                 read_data_core <= 1'b1;
            if (reg_push_i && full)  overflow       <= 1'b1;
            if (core_ct_valid_i) begin
                ct_o     <= core_ct_i;
                ct_valid <= 1'b1;
            end
            if (core_tag_valid_i) begin
                tag_o     <= core_tag_i;
                ready_tag <= 1'b1;
            end
            if (core_done_i) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ascon_block_feeder.sv
// Directed table-driven bench for ascon_block_feeder (pDEPTH=2), plus hand
// sequences for ct/tag/done capture, padding and mid-run reset.
module tb_ascon_block_feeder;

    logic         crypto_clk = 1'b0;
    logic         reset;
    logic         start_i, reg_push_i;
    logic [127:0] reg_data_i;
    logic [4:0]   reg_vbytes_i;
    logic         reg_last_i, reg_eot_i, reg_sel_i;
    logic         reg_full_o;
    logic [127:0] core_data_o;
    logic [4:0]   core_vbytes_o;
    logic         core_last_o, core_eot_o, core_sel_o, core_valid_o;
    logic         core_ready_i;
    logic [127:0] core_ct_i, core_tag_i;
    logic         core_ct_valid_i, core_tag_valid_i, core_done_i;
    logic [127:0] ct_o, tag_o;
    logic [7:0]   status_o;

    int checks = 0;
    int errors = 0;

    always #5 crypto_clk = ~crypto_clk;

    ascon_block_feeder #(.pDEPTH(2)) dut (
        .crypto_clk(crypto_clk), .reset(reset), .start_i(start_i),
        .reg_push_i(reg_push_i), .reg_data_i(reg_data_i), .reg_vbytes_i(reg_vbytes_i),
        .reg_last_i(reg_last_i), .reg_eot_i(reg_eot_i), .reg_sel_i(reg_sel_i),
        .reg_full_o(reg_full_o), .core_data_o(core_data_o), .core_vbytes_o(core_vbytes_o),
        .core_last_o(core_last_o), .core_eot_o(core_eot_o), .core_sel_o(core_sel_o),
        .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
        .core_ct_i(core_ct_i), .core_ct_valid_i(core_ct_valid_i),
        .core_tag_i(core_tag_i), .core_tag_valid_i(core_tag_valid_i),
        .core_done_i(core_done_i), .ct_o(ct_o), .tag_o(tag_o), .status_o(status_o)
    );

    typedef struct {
        logic         start;
        logic         push;
        logic [127:0] data;
        logic [4:0]   vb;
        logic [2:0]   flg;
        logic         ready;
        logic         exp_valid;
        logic [127:0] exp_data;
        logic [4:0]   exp_vb;
        logic [2:0]   exp_flg;
        logic         exp_full;
        logic [7:0]   exp_status;
    } vec_t;

    localparam logic [127:0] BLK_A = 128'h12345678_abcdef01_87654321_deadbeef;
    localparam logic [127:0] BLK_B = 128'h0badf00d_00000001_00000002_00000003;
    localparam logic [127:0] BLK_C = 128'hcccccccc_cccccccc_cccccccc_cccccccc;
    localparam logic [127:0] BLK_D = 128'hd0d1d2d3_d4d5d6d7_d8d9dadb_dcdddedf;
    localparam logic [127:0] BLK_E = 128'he0000000_00000000_00000000_0000000e;
    localparam logic [127:0] BLK_F = 128'hffffffff_00000000_ffffffff_00000000;
    localparam logic [127:0] BLK_G = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] CT    = 128'h8a278bf8fa2812bc39e52c76205af377;
    localparam logic [127:0] TAG   = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
    localparam logic [127:0] PAD_IN  = 128'hf1023000_11111111_22222222_33333333;
`ifdef ASCON_FEEDER_PAD_EN
    localparam logic [127:0] PAD_EXP = 128'hf1023080_00000000_00000000_00000000;
`else
    localparam logic [127:0] PAD_EXP = PAD_IN;
`endif

    vec_t tbl [12];

    function automatic vec_t mk(input logic st, input logic pu, input logic [127:0] d,
                                input logic [4:0] vb, input logic [2:0] fl, input logic rd,
                                input logic ev, input logic [127:0] ed, input logic [4:0] evb,
                                input logic [2:0] efl, input logic ef, input logic [7:0] es);
        vec_t v;
        v.start = st; v.push = pu; v.data = d; v.vb = vb; v.flg = fl; v.ready = rd;
        v.exp_valid = ev; v.exp_data = ed; v.exp_vb = evb; v.exp_flg = efl;
        v.exp_full = ef; v.exp_status = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge crypto_clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_i = 0; reg_push_i = 0; reg_data_i = '0; reg_vbytes_i = '0;
        reg_last_i = 0; reg_eot_i = 0; reg_sel_i = 0; core_ready_i = 0;
        core_ct_i = '0; core_ct_valid_i = 0; core_tag_i = '0; core_tag_valid_i = 0;
        core_done_i = 0;
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_valid"},  128'(core_valid_o), 128'(0));
        check({tag, "_full"},   128'(reg_full_o),   128'(0));
        check({tag, "_status"}, 128'(status_o),     128'(0));
        check({tag, "_data"},   core_data_o,        128'(0));
        check({tag, "_ct"},     ct_o,               128'(0));
        check({tag, "_tag"},    tag_o,              128'(0));
    endtask

    initial begin
        // Rows: inputs for one cycle, then outputs expected just after that edge.
        tbl[0]  = mk(0,1,BLK_A,16,3'b000,0, 0,BLK_A,16,3'b000,0,8'h00);
        tbl[1]  = mk(0,1,BLK_B,16,3'b100,0, 0,BLK_A,16,3'b000,1,8'h00);
        tbl[2]  = mk(0,1,BLK_C,16,3'b011,0, 0,BLK_A,16,3'b000,1,8'h20);
        tbl[3]  = mk(1,0,'0,   0, 3'b000,0, 1,BLK_A,16,3'b000,1,8'h01);
        tbl[4]  = mk(0,0,'0,   0, 3'b000,1, 1,BLK_B,16,3'b100,0,8'h03);
        tbl[5]  = mk(0,1,BLK_D,16,3'b001,1, 1,BLK_D,16,3'b001,0,8'h03);
        tbl[6]  = mk(0,0,'0,   0, 3'b000,1, 0,'0,    0,3'b000,0,8'h03);
        tbl[7]  = mk(0,1,BLK_E,16,3'b001,1, 1,BLK_E,16,3'b001,0,8'h01);
        tbl[8]  = mk(0,1,BLK_F,16,3'b101,0, 1,BLK_E,16,3'b001,1,8'h01);
        tbl[9]  = mk(0,0,'0,   0, 3'b000,1, 1,BLK_F,16,3'b101,0,8'h03);
        tbl[10] = mk(0,1,BLK_G,20,3'b111,1, 1,BLK_G,16,3'b111,0,8'h03);
        tbl[11] = mk(0,0,'0,   0, 3'b000,1, 0,'0,    0,3'b000,0,8'h03);

        idle_inputs();
        reset = 1;
        #2;
        check_all_clear("reset");
        tick(); tick();
        reset = 0;

        for (int i = 0; i < 12; i++) begin
            start_i = tbl[i].start; reg_push_i = tbl[i].push; reg_data_i = tbl[i].data;
            reg_vbytes_i = tbl[i].vb; {reg_last_i, reg_eot_i, reg_sel_i} = tbl[i].flg;
            core_ready_i = tbl[i].ready;
            tick();
            check($sformatf("row%0d_valid", i),  128'(core_valid_o),  128'(tbl[i].exp_valid));
            check($sformatf("row%0d_data", i),   core_data_o,         tbl[i].exp_data);
            check($sformatf("row%0d_vbytes", i), 128'(core_vbytes_o), 128'(tbl[i].exp_vb));
            check($sformatf("row%0d_flags", i),
                  128'({core_last_o, core_eot_o, core_sel_o}), 128'(tbl[i].exp_flg));
            check($sformatf("row%0d_full", i),   128'(reg_full_o),    128'(tbl[i].exp_full));
            check($sformatf("row%0d_status", i), 128'(status_o),      128'(tbl[i].exp_status));
        end
        idle_inputs();

        // ct / tag / done capture from a fresh reset.
        reset = 1; tick(); reset = 0;
        start_i = 1; tick(); start_i = 0;
        check("go_status", 128'(status_o), 128'(8'h01));
        core_ct_i = CT; core_ct_valid_i = 1; tick(); core_ct_valid_i = 0; core_ct_i = '0;
        check("ct_value", ct_o, CT);
        check("ct_status", 128'(status_o), 128'(8'h05));
        core_tag_i = TAG; core_tag_valid_i = 1; tick(); core_tag_valid_i = 0; core_tag_i = '0;
        check("tag_value", tag_o, TAG);
        check("tag_status", 128'(status_o), 128'(8'h0D));
        start_i = 1; tick(); start_i = 0;
        check("start_in_run_ignored", 128'(status_o), 128'(8'h0D));
        core_done_i = 1; tick(); core_done_i = 0;
        check("done_status", 128'(status_o), 128'(8'h1C));
        check("done_ct_held", ct_o, CT);

        // Padding at push (raw when the padding build is off).
        reg_push_i = 1; reg_data_i = PAD_IN; reg_vbytes_i = 3; tick();
        check("pad_data", core_data_o, PAD_EXP);
        check("pad_vbytes", 128'(core_vbytes_o), 128'(5'd3));
        reg_data_i = BLK_B; reg_vbytes_i = 16; tick(); reg_push_i = 0;
        check("pad_full", 128'(reg_full_o), 128'(1));
        start_i = 1; tick(); start_i = 0;
        check("rerun_status", 128'(status_o), 128'(8'h01));
        check("rerun_valid", 128'(core_valid_o), 128'(1));

        // Reset mid-RUN with two entries queued.
        reset = 1;
        #2;
        check_all_clear("midreset_async");
        tick();
        check_all_clear("midreset");
        reset = 0;
        tick();
        check("post_reset_valid", 128'(core_valid_o), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
